ro_sensor_array: RTL and testbench
==================================

Name: ro_sensor_array

Overview:
- Parametrised array of NUM_RO ring-oscillator aging/reliability sensors with one shared frequency-measurement controller.
- Each ring is built from STAGES inverting cells with the transfer function out = !(in1 & !in2):
  - in1 is the ring feedback.
  - in2 is an active-high kill; kill=1 forces the cell output to 1 and stops the ring.
- The controller enables one selected ring, lets it settle, then counts prescaled ring edges over a programmable clk window and reports the count.
- The block sits behind the sensor IP's register interface.

Parameters:
- NUM_RO, 4, number of rings (1..16).
- STAGES, 5, cells per ring; must be odd and ≥3. An even value is an elaboration error.
- DIV_LOG2, 4, ring-domain prescaler: the ring is divided by 2^DIV_LOG2 before synchronisation.
- CNT_W, 24, width of the result counter.
- WIN_W, 20, width of the window-length input.
- SETTLE_CYC, 16, clk cycles the ring runs before counting starts.
- SYNC_STAGES, 3, synchroniser depth (≥2).
- SIM_DELAY, 1, per-cell delay in ns for simulation only; ignored by synthesis.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse requesting a measurement.
- ro_sel  in  4  ring index to measure.
- window  in  WIN_W  measurement length in clk cycles.
- busy  out  1  measurement in progress.
- done  out  1  one-cycle pulse when the result is valid.
- count  out  CNT_W  prescaled rising-edge count of the last measurement.
- overflow  out  1  count saturated in the last measurement.
- sel_err  out  1  last request had ro_sel ≥ NUM_RO.

Behaviour:
- Reset values: busy=0, done=0, count=0, overflow=0, sel_err=0, FSM=IDLE, all rings killed, prescaler flops=0, synchroniser=0.
- Reset is async-asserted and applies to both clk-domain and ring-domain flops. Deassertion in the clk domain is synchronised internally.
- Rings: exactly one ring may be un-killed at a time (kill_n[i] = ring_en & (sel_q==i)); all others stay killed.
  - sel_q is latched at start.
  - The ring output drives a DIV_LOG2-bit toggle prescaler clocked by the ring.
  - The prescaler MSB passes through a SYNC_STAGES flop chain into clk, then a rising-edge detector.
  - Maximum usable ring frequency < clk_freq·2^DIV_LOG2/2.
- FSM states: IDLE, SETTLE, MEASURE, DRAIN, DONE.
- IDLE:
  - start=1 latches ro_sel and window, and clears count, overflow and sel_err.
  - If ro_sel ≥ NUM_RO: set sel_err=1 and go to DONE without enabling any ring.
  - Otherwise go to SETTLE with ring_en=1 and busy=1. busy rises the cycle after start.
- SETTLE: wait SETTLE_CYC cycles; edges are ignored. Then go to MEASURE, or go to DRAIN directly if window==0 (count stays 0).
- MEASURE:
  - Increment count on each synchronised rising edge for exactly `window` cycles.
  - Counting saturates at all-ones and sets overflow=1.
  - After the last window cycle, go to DRAIN with ring_en=0.
- DRAIN: wait SYNC_STAGES+1 cycles with no counting, so late edges are discarded. Then go to DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, return to IDLE. count, overflow and sel_err hold until the next accepted start.
- start while busy is ignored; there is no queueing.
- start in the DONE cycle is ignored; start is accepted from the following IDLE cycle.
- ro_sel and window changes while busy have no effect.
- Reset mid-measurement: everything returns to reset values immediately and the ring is killed. No done pulse is produced.
- Latency: done asserts SETTLE_CYC + window + SYNC_STAGES + 3 cycles after the start cycle (window≥1). For sel_err it asserts 2 cycles after start.

Test Plan:
- Basic measurement: clk 100 MHz, SIM_DELAY=1 (ring period 10 ns); start with ro_sel=0, window=1000 -> done at cycle 1000+16+3+3; count=62 or 63; overflow=0; sel_err=0.
- Channel isolation: start with ro_sel=2 -> only ring 2 toggles (kill_n one-hot); rings 0, 1 and 3 are held at 1 throughout. Repeat for ro_sel=3 -> same count ±1.
- Invalid selection: ro_sel=7 with NUM_RO=4 -> done 2 cycles after start; sel_err=1; count=0; no ring toggles.
- Zero window and saturation:
  - window=0 -> count=0, done at cycle 16+4+2.
  - CNT_W=4, window=1000 -> count=15, overflow=1.
- Start while busy, then reset mid-run:
  - start pulsed during MEASURE -> ignored; single done; count unchanged by the second pulse.
  - resetn low during MEASURE -> busy=0, count=0, rings killed, no done. A new start afterwards measures normally.

Source files
------------

// File: rtl/ro_sensor_array.sv
// Ring-oscillator aging sensor array: one ring runs at a time. Its prescaled
// output is synchronised into clk and its rising edges are counted over a window.
module ro_cell #(
  parameter int SIM_DELAY = 1
) (
  input  logic in1,
  input  logic in2,
  output logic out
);
  timeunit 1ns;
  timeprecision 1ps;

  // The delay only sets the simulated ring period; synthesis drops it.
  assign #(SIM_DELAY) out = ~(in1 & ~in2);
endmodule

module ro_sensor_array #(
  parameter int NUM_RO      = 4,
  parameter int STAGES      = 5,
  parameter int DIV_LOG2    = 4,
  parameter int CNT_W       = 24,
  parameter int WIN_W       = 20,
  parameter int SETTLE_CYC  = 16,
  parameter int SYNC_STAGES = 3,
  parameter int SIM_DELAY   = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [3:0]       ro_sel,
  input  logic [WIN_W-1:0] window,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             sel_err
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (WIN_W > SETTLE_W) ? WIN_W : SETTLE_W;
  localparam logic [4:0] NUM_RO_W = 5'(NUM_RO);

  if ((STAGES % 2) == 0 || STAGES < 3) begin : g_bad_stages
    $error("ro_sensor_array: STAGES must be odd and >= 3");
  end
  if (NUM_RO < 1 || NUM_RO > 16) begin : g_bad_num_ro
    $error("ro_sensor_array: NUM_RO must be 1..16");
  end
  if (SYNC_STAGES < 2 || DIV_LOG2 < 1 || SETTLE_CYC < 1) begin : g_bad_misc
    $error("ro_sensor_array: SYNC_STAGES >= 2, DIV_LOG2 >= 1, SETTLE_CYC >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEASURE, S_DRAIN, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         sel_q, sel_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ring_en_q, ring_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               sel_err_q, sel_err_d;

  // Reset asserts asynchronously everywhere; release is synchronised to clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [NUM_RO-1:0] kill_n;
  logic [NUM_RO-1:0] ro_out;
  logic [NUM_RO-1:0] pre_msb;

  for (genvar i = 0; i < NUM_RO; i++) begin : g_ring
    logic [STAGES-1:0]   node;
    logic [DIV_LOG2-1:0] pre_q, pre_d;

    assign kill_n[i] = ring_en_q & (sel_q == 4'(i));

    // Only the first cell takes the kill: it parks the ring at all-alternating
    // levels so it restarts as a single travelling edge.
    for (genvar s = 0; s < STAGES; s++) begin : g_cell
      if (s == 0) begin : g_head
        ro_cell #(.SIM_DELAY(SIM_DELAY)) u_cell (
          .in1 (node[STAGES-1]),
          .in2 (~kill_n[i]),
          .out (node[0])
        );
      end else begin : g_body
        ro_cell #(.SIM_DELAY(SIM_DELAY)) u_cell (
          .in1 (node[s-1]),
          .in2 (1'b0),
          .out (node[s])
        );
      end
    end

    assign ro_out[i] = node[STAGES-1];
    assign pre_d     = pre_q + DIV_LOG2'(1);

    always_ff @(posedge ro_out[i] or negedge resetn) begin
      if (!resetn) pre_q <= '0;
      else         pre_q <= pre_d;
    end
    assign pre_msb[i] = pre_q[DIV_LOG2-1];
  end

  // sel_q is stable for the whole run, so this mux never switches mid-count.
  logic sel_msb;
  always_comb begin
    sel_msb = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (sel_q == 4'(i)) sel_msb = pre_msb[i];
    end
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   ro_edge;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], sel_msb};
  assign prev_d  = sync_q[SYNC_STAGES-1];
  assign ro_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    win_d     = win_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    ring_en_d = ring_en_q;
    ovf_d     = ovf_q;
    sel_err_d = sel_err_q;
    done_d    = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        // done_q marks the cycle right after DONE, where start is still refused.
        if (start && !done_q) begin
          sel_d     = ro_sel;
          win_d     = window;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          sel_err_d = 1'b0;
          if ({1'b0, ro_sel} >= NUM_RO_W) begin
            sel_err_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            ring_en_d = 1'b1;
            tmr_d     = TMR_W'(SETTLE_CYC - 1);
            state_d   = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (tmr_q == '0) begin
          if (win_q == '0) begin
            ring_en_d = 1'b0;
            tmr_d     = TMR_W'(SYNC_STAGES);
            state_d   = S_DRAIN;
          end else begin
            tmr_d   = TMR_W'(win_q) - TMR_W'(1);
            state_d = S_MEASURE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_MEASURE: begin
        if (ro_edge) begin
          if (&cnt_q) ovf_d = 1'b1;
          else        cnt_d = cnt_q + CNT_W'(1);
        end
        if (tmr_q == '0) begin
          ring_en_d = 1'b0;
          tmr_d     = TMR_W'(SYNC_STAGES);
          state_d   = S_DRAIN;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_DRAIN: begin
        if (tmr_q == '0) state_d = S_DONE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      win_q     <= '0;
      tmr_q     <= '0;
      cnt_q     <= '0;
      ring_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      sel_err_q <= 1'b0;
      sync_q    <= '0;
      prev_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      win_q     <= win_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      ring_en_q <= ring_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      sel_err_q <= sel_err_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = cnt_q;
  assign overflow = ovf_q;
  assign sel_err  = sel_err_q;
endmodule

// File: tb/tb_ro_sensor_array.sv
// Bench for ro_sensor_array: directed and random measurements against a
// timing/frequency model, plus a 4-bit-counter instance for saturation.
module tb_ro_sensor_array;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int NUM_RO      = 4;
  localparam int STAGES      = 5;
  localparam int DIV_LOG2    = 4;
  localparam int CNT_W       = 24;
  localparam int WIN_W       = 20;
  localparam int SETTLE_CYC  = 16;
  localparam int SYNC_STAGES = 3;
  localparam int SIM_DELAY   = 1;
  localparam int CLK_NS      = 10;
  localparam int SAT_W       = 4;
  localparam longint SAT_MAX = 15;
  // One prescaled ring period in ns.
  localparam longint EDGE_NS = 2 * STAGES * SIM_DELAY * (2 ** DIV_LOG2);

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       ro_sel = '0;
  logic [WIN_W-1:0] window = '0;
  logic             busy, done, overflow, sel_err;
  logic [CNT_W-1:0] count;
  logic             s_busy, s_done, s_ovf, s_sel_err;
  logic [SAT_W-1:0] s_count;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int tog[NUM_RO];
  logic [NUM_RO-1:0] prev_ro = '1;

  ro_sensor_array #(
    .NUM_RO(NUM_RO), .STAGES(STAGES), .DIV_LOG2(DIV_LOG2), .CNT_W(CNT_W),
    .WIN_W(WIN_W), .SETTLE_CYC(SETTLE_CYC), .SYNC_STAGES(SYNC_STAGES),
    .SIM_DELAY(SIM_DELAY)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .ro_sel(ro_sel), .window(window),
    .busy(busy), .done(done), .count(count), .overflow(overflow), .sel_err(sel_err)
  );

  ro_sensor_array #(
    .NUM_RO(NUM_RO), .STAGES(STAGES), .DIV_LOG2(DIV_LOG2), .CNT_W(SAT_W),
    .WIN_W(WIN_W), .SETTLE_CYC(SETTLE_CYC), .SYNC_STAGES(SYNC_STAGES),
    .SIM_DELAY(SIM_DELAY)
  ) dut_sat (
    .clk(clk), .resetn(resetn), .start(start), .ro_sel(ro_sel), .window(window),
    .busy(s_busy), .done(s_done), .count(s_count), .overflow(s_ovf), .sel_err(s_sel_err)
  );

  always #(CLK_NS / 2) clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial for (int i = 0; i < NUM_RO; i++) tog[i] = 0;

  always @(dut.ro_out) begin
    for (int i = 0; i < NUM_RO; i++) if (dut.ro_out[i] !== prev_ro[i]) tog[i]++;
    prev_ro = dut.ro_out;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input longint obs, input longint lo, input longint hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Runs one measurement. poke_cyc>0 pulses start again that many cycles in;
  // poke_done pulses an invalid start in the done cycle. got returns count.
  task automatic measure(input logic [3:0] sel, input int w, input int poke_cyc,
                         input bit poke_done, output longint got);
    int cyc, exp_lat, dc0;
    int tog0[NUM_RO];
    bit valid;
    longint lo, hi, delta;
    valid = (sel < NUM_RO);
    dc0 = done_cnt;
    for (int i = 0; i < NUM_RO; i++) tog0[i] = tog[i];
    if (!valid)      exp_lat = 2;
    else if (w == 0) exp_lat = SETTLE_CYC + SYNC_STAGES + 1 + 2;
    else             exp_lat = SETTLE_CYC + w + SYNC_STAGES + 3;
    lo = (longint'(w) * CLK_NS) / EDGE_NS;
    hi = (longint'(w) * CLK_NS + EDGE_NS - 1) / EDGE_NS;

    @(negedge clk);
    start = 1'b1; ro_sel = sel; window = WIN_W'(w);
    @(negedge clk);
    start = 1'b0;
    ro_sel = 4'($urandom_range(0, 15));
    window = WIN_W'($urandom);
    cyc = 1;
    if (valid) check("busy_rise", busy, 1);
    while (!done && cyc < w + 100) begin
      start = (poke_cyc != 0 && cyc == poke_cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("latency", cyc, exp_lat);
    check("busy_at_done", busy, 0);
    check("sel_err", sel_err, !valid);
    check("sat_done", s_done, 1);
    check("sat_busy", s_busy, 0);
    check("sat_sel_err", s_sel_err, !valid);
    if (valid) begin
      check_rng("count", count, lo, hi);
      check("overflow", overflow, 0);
      check_rng("sat_count", s_count, (lo < SAT_MAX) ? lo : SAT_MAX, (hi < SAT_MAX) ? hi : SAT_MAX);
      if (lo > SAT_MAX)        check("sat_overflow", s_ovf, 1);
      else if (hi <= SAT_MAX)  check("sat_overflow", s_ovf, 0);
    end else begin
      check("count_inv", count, 0);
      check("sat_count_inv", s_count, 0);
    end
    for (int i = 0; i < NUM_RO; i++) begin
      delta = tog[i] - tog0[i];
      if (valid && i == int'(sel)) check("ring_ran", delta > 0, 1);
      else                         check("ring_idle", delta, 0);
    end
    check("rings_parked", dut.ro_out, (1 << NUM_RO) - 1);
    got = count;

    if (poke_done) begin
      start = 1'b1;
      ro_sel = 4'd7;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("sel_err_held", sel_err, !valid);
    check("count_held", count, got);
    repeat (2) @(negedge clk);
    check("single_done", done_cnt - dc0, 1);
  endtask

  initial begin
    longint c2, c3, tmp;
    int sel_r, w_r;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_sel_err", sel_err, 0);
    check("rst_rings", dut.ro_out, (1 << NUM_RO) - 1);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    measure(4'd0, 1000, 0, 1'b0, tmp);
    measure(4'd2, 1000, 0, 1'b0, c2);
    measure(4'd3, 1000, 0, 1'b0, c3);
    check_rng("ring3_vs_ring2", c3, c2 - 1, c2 + 1);
    measure(4'd7, 1000, 0, 1'b0, tmp);
    measure(4'd1, 0, 0, 1'b0, tmp);
    measure(4'd1, 1, 0, 1'b0, tmp);
    measure(4'd0, 300, 100, 1'b0, tmp);
    measure(4'd2, 50, 0, 1'b1, tmp);

    // Reset in the middle of a measurement.
    @(negedge clk);
    start = 1'b1; ro_sel = 4'd1; window = WIN_W'(500);
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    check("midrun_busy", busy, 1);
    tmp = done_cnt;
    resetn = 1'b0;
    #2;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_count", count, 0);
    check("rst_mid_done", done, 0);
    #8;
    check("rst_mid_rings", dut.ro_out, (1 << NUM_RO) - 1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (600) @(negedge clk);
    check("rst_no_done", done_cnt - tmp, 0);
    check("rst_still_idle", busy, 0);
    measure(4'd1, 500, 0, 1'b0, tmp);

    for (int k = 0; k < 8; k++) begin
      sel_r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NUM_RO - 1);
      w_r = $urandom_range(0, 400);
      measure(4'(sel_r), w_r, 0, 1'b0, tmp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
